serial_add_seq: RTL and testbench

- Bit-serial adder sequencer for the ripple-carry adder datapath.
- Latches two WIDTH-bit operands and a carry-in, then presents one operand bit pair per clock, LSB first, to a single one-bit full-adder slice.
- Feeds that slice's carry output back through a carry flip-flop and accumulates the sum bits in a shift register.
- Provides an area-minimal alternative to the WIDTH-slice combinational ripple chain, behind a start/busy/done handshake.

---
 rtl/serial_add_seq_if.sv | 24 ++
 rtl/serial_add_seq.sv | 95 +++++++++
 tb/tb_serial_add_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_seq_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The master side requests an addition; the slave side performs it.
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder slice reused WIDTH times,
// LSB first, with the carry held in a flip-flop between bits. Operands are
// latched on the accepting edge; the result is published on completion and
// held until the next completion.
module serial_add_seq #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_add_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic             last_bit;
  logic [WIDTH-1:0] sum_next;

  // Single full-adder slice working on the current LSB pair and stored carry.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    c_bit    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    sum_next = {s_bit, sum_sr[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  // Sequencer FSM and serial datapath; the result registers load only on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are few flops, not a memory, so all of them reset.
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // start and the operand inputs are deliberately ignored while running.
          carry  <= c_bit;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= sum_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum_q  <= sum_next;
            cout_q <= c_bit;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded purely from the registered state; no input reaches an output combinationally.
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=3.
// Expected results are queued when a request is driven and compared when
// the DUT raises done; every comparison goes through check().
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_seq_if #(.WIDTH(8)) bus8 ();
  serial_add_seq_if #(.WIDTH(3)) bus3 ();

  serial_add_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_seq #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [8:0] exp8;
  logic [3:0] exp3;
  logic [7:0] last8 = '0;
  logic [2:0] last3 = '0;
  int         done_cnt8 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    bus8.start = 1'b1;
    push8(a, b, cin);
  endtask

  // Wait at falling edges for done, bounded by budget cycles.
  task automatic wait_done8(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus8.done) return;
      @(negedge clk);
    end
    check("done_timeout8", bus8.done, 1);
  endtask

  // Scoreboard and stability monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '0;
    end else if (bus8.done) begin
      done_cnt8++;
      check("busy_in_done8", bus8.busy, 0);
      if (q8.size() == 0) begin
        check("spurious_done8", bus8.done, 0);
      end else begin
        exp8 = q8.pop_front();
        check("sum8", bus8.sum, exp8[7:0]);
        check("cout8", bus8.cout, exp8[8]);
      end
      last8 = bus8.sum;
    end else begin
      check("sum8_stable", bus8.sum, last8);
    end
  end

  // Scoreboard and stability monitor for the 3-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      last3 = '0;
    end else if (bus3.done) begin
      check("busy_in_done3", bus3.busy, 0);
      if (q3.size() == 0) begin
        check("spurious_done3", bus3.done, 0);
      end else begin
        exp3 = q3.pop_front();
        check("sum3", bus3.sum, exp3[2:0]);
        check("cout3", bus3.cout, exp3[3]);
      end
      last3 = bus3.sum;
    end else begin
      check("sum3_stable", bus3.sum, last3);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    int t1;
    int t2;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    check("rst_sum3", bus3.sum, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x5A + 0x3C: busy for 8 cycles after acceptance, done in the ninth.
    drive8(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t1_busy", bus8.busy, 1);
      check("t1_nodone", bus8.done, 0);
      @(negedge clk);
    end
    check("t1_done", bus8.done, 1);
    check("t1_done_busy", bus8.busy, 0);
    @(negedge clk);
    check("t1_done_pulse", bus8.done, 0);

    // Full carry ripple, then all-ones plus carry-in.
    drive8(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(20);
    @(negedge clk);
    drive8(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(20);
    @(negedge clk);

    // A request and operand changes during RUN are ignored.
    d0 = done_cnt8;
    drive8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'h33; bus8.b = 8'hCC;
    repeat (15) @(negedge clk);
    check("midrun_done_count", done_cnt8 - d0, 1);

    // Reset during RUN discards the partial result without a done pulse.
    drive8(8'hF0, 8'h0F, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_sum", bus8.sum, 0);
    check("rst_mid_cout", bus8.cout, 0);
    check("rst_mid_busy", bus8.busy, 0);
    check("rst_mid_done", bus8.done, 0);
    q8.delete();
    d0 = done_cnt8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt8 - d0, 0);
    check("rst_idle", bus8.busy, 0);
    drive8(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(20);
    @(negedge clk);

    // start held high: DONE re-accepts with no idle bubble, so pulses are
    // WIDTH+1 edges apart (eight non-done cycles between them).
    drive8(8'h01, 8'h02, 1'b0);
    @(negedge clk);
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    push8(8'h80, 8'h80, 1'b0);
    n = 0;
    while (!bus8.done && n < 30) begin @(negedge clk); n++; end
    t1 = n;
    @(negedge clk); n++;
    check("b2b_no_bubble", bus8.busy, 1);
    while (!bus8.done && n < 60) begin @(negedge clk); n++; end
    t2 = n;
    bus8.start = 1'b0;
    check("b2b_spacing", t2 - t1, 9);
    @(negedge clk);
    check("b2b_stop", bus8.busy, 0);

    // Randomised operations on both widths, with junk requests while busy.
    fork
      begin
        int issued8 = 0;
        int guard8 = 0;
        while (issued8 < 500 && guard8 < 20000) begin
          @(negedge clk);
          guard8++;
          if (bus8.busy) begin
            bus8.start = 1'($urandom_range(1));
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
          end else if ($urandom_range(3) != 0) begin
            drive8(8'($urandom), 8'($urandom), 1'($urandom));
            issued8++;
          end else begin
            bus8.start = 1'b0;
          end
        end
        @(negedge clk);
        bus8.start = 1'b0;
        guard8 = 0;
        while (q8.size() != 0 && guard8 < 100) begin @(negedge clk); guard8++; end
        check("drain8", q8.size(), 0);
      end
      begin
        int issued3 = 0;
        int guard3 = 0;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       rc;
        while (issued3 < 500 && guard3 < 20000) begin
          @(negedge clk);
          guard3++;
          if (bus3.busy) begin
            bus3.start = 1'($urandom_range(1));
            bus3.a = 3'($urandom); bus3.b = 3'($urandom); bus3.cin = 1'($urandom);
          end else if ($urandom_range(3) != 0) begin
            ra = 3'($urandom); rb = 3'($urandom); rc = 1'($urandom);
            bus3.a = ra; bus3.b = rb; bus3.cin = rc; bus3.start = 1'b1;
            q3.push_back({1'b0, ra} + {1'b0, rb} + 4'(rc));
            issued3++;
          end else begin
            bus3.start = 1'b0;
          end
        end
        @(negedge clk);
        bus3.start = 1'b0;
        guard3 = 0;
        while (q3.size() != 0 && guard3 < 100) begin @(negedge clk); guard3++; end
        check("drain3", q3.size(), 0);
      end
    join

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
